// File: rtl/ahb_m2s_pipelined_mux_if.sv
// Bus bundle for the AHB master-to-slave pipelined mux.
// Optional M2S_PERF_CNT_EN adds the beat-counter clear input and counter outputs.
interface ahb_m2s_pipelined_mux_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    localparam int MW = $clog2(NUM_MASTERS);
    localparam int SW = DATA_WIDTH / 8;

    logic [MW-1:0]                          Hmaster;
    logic                                   Hready;
    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] Haddr_M;
    logic [NUM_MASTERS-1:0][1:0]            Htrans_M;
    logic [NUM_MASTERS-1:0]                 Hwrite_M;
    logic [NUM_MASTERS-1:0][2:0]            Hsize_M;
    logic [NUM_MASTERS-1:0][2:0]            Hburst_M;
    logic [NUM_MASTERS-1:0]                 Hmastlock_M;
    logic [NUM_MASTERS-1:0][SW-1:0]         Hstrob_M;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] Hwdata_M;

    logic [ADDR_WIDTH-1:0]                  Haddr;
    logic [1:0]                             Htrans;
    logic                                   Hwrite;
    logic [2:0]                             Hsize;
    logic [2:0]                             Hburst;
    logic                                   Hmastlock;
    logic [SW-1:0]                          Hstrob;
    logic [DATA_WIDTH-1:0]                  Hwdata;
    logic [MW-1:0]                          Hmaster_D;
    logic                                   Hdphase_vld;
    logic                                   Hhandover_err;
`ifdef M2S_PERF_CNT_EN
    logic                                   Hcnt_clr;
    logic [NUM_MASTERS-1:0][31:0]           Hbeat_cnt;
`endif

    modport master (
`ifdef M2S_PERF_CNT_EN
        output Hcnt_clr,
        input  Hbeat_cnt,
`endif
        output Hmaster, Hready, Haddr_M, Htrans_M, Hwrite_M, Hsize_M, Hburst_M,
               Hmastlock_M, Hstrob_M, Hwdata_M,
        input  Haddr, Htrans, Hwrite, Hsize, Hburst, Hmastlock, Hstrob, Hwdata,
               Hmaster_D, Hdphase_vld, Hhandover_err
    );

    modport slave (
`ifdef M2S_PERF_CNT_EN
        input  Hcnt_clr,
        output Hbeat_cnt,
`endif
        input  Hmaster, Hready, Haddr_M, Htrans_M, Hwrite_M, Hsize_M, Hburst_M,
               Hmastlock_M, Hstrob_M, Hwdata_M,
        output Haddr, Htrans, Hwrite, Hsize, Hburst, Hmastlock, Hstrob, Hwdata,
               Hmaster_D, Hdphase_vld, Hhandover_err
    );
endinterface

// File: rtl/ahb_m2s_pipelined_mux.sv
// AHB master-to-slave mux: address phase follows Hmaster, write data follows the registered
// data-phase owner. Define M2S_PERF_CNT_EN to add saturating per-master beat counters.
module ahb_m2s_pipelined_mux #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input logic                    Hclk,
    input logic                    Hresetn,
    ahb_m2s_pipelined_mux_if.slave bus
);
    localparam int MW = $clog2(NUM_MASTERS);
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    logic [ADDR_WIDTH-1:0] haddr_s;
    logic [1:0]            htrans_s;
    logic                  hwrite_s;
    logic [2:0]            hsize_s;
    logic [2:0]            hburst_s;
    logic                  hmastlock_s;
    logic [SW-1:0]         hstrob_s;
    logic [DATA_WIDTH-1:0] hwdata_s;
    logic                  handover_err_d;

    // hmaster_d_q doubles as the previous accepted address-phase owner for the handover check
    logic [MW-1:0]         hmaster_d_q;
    logic                  dphase_vld_q;
    logic                  lock_active_q;
    logic                  handover_err_q;

    // Address-phase AND-OR select; an index with no matching master leaves everything zero (IDLE)
    always_comb begin
        haddr_s     = '0;
        htrans_s    = HTRANS_IDLE;
        hwrite_s    = 1'b0;
        hsize_s     = 3'b000;
        hburst_s    = 3'b000;
        hmastlock_s = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            haddr_s     = haddr_s     | ({ADDR_WIDTH{bus.Hmaster == MW'(i)}} & bus.Haddr_M[i]);
            htrans_s    = htrans_s    | ({2{bus.Hmaster == MW'(i)}} & bus.Htrans_M[i]);
            hwrite_s    = hwrite_s    | ((bus.Hmaster == MW'(i)) & bus.Hwrite_M[i]);
            hsize_s     = hsize_s     | ({3{bus.Hmaster == MW'(i)}} & bus.Hsize_M[i]);
            hburst_s    = hburst_s    | ({3{bus.Hmaster == MW'(i)}} & bus.Hburst_M[i]);
            hmastlock_s = hmastlock_s | ((bus.Hmaster == MW'(i)) & bus.Hmastlock_M[i]);
        end
    end

    // Data-phase select by registered owner, gated by an active data phase
    always_comb begin
        hwdata_s = '0;
        hstrob_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            hwdata_s = hwdata_s | ({DATA_WIDTH{dphase_vld_q && (hmaster_d_q == MW'(i))}} & bus.Hwdata_M[i]);
            hstrob_s = hstrob_s | ({SW{dphase_vld_q && (hmaster_d_q == MW'(i))}} & bus.Hstrob_M[i]);
        end
    end

    // Illegal handover: new owner opens with SEQ, or a locked active sequence is abandoned
    always_comb begin
        handover_err_d = 1'b0;
        if (bus.Hready) begin
            handover_err_d = (bus.Hmaster != hmaster_d_q) &&
                             ((htrans_s == HTRANS_SEQ) || lock_active_q);
        end else begin
            handover_err_d = 1'b0;
        end
    end

    // Data-phase owner and handover history, advanced only on accepting edges
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            hmaster_d_q    <= '0;
            dphase_vld_q   <= 1'b0;
            lock_active_q  <= 1'b0;
            handover_err_q <= 1'b0;
        end else begin
            handover_err_q <= handover_err_d;
            if (bus.Hready) begin
                hmaster_d_q   <= bus.Hmaster;
                dphase_vld_q  <= htrans_s[1];
                lock_active_q <= hmastlock_s && (htrans_s != HTRANS_IDLE);
            end
        end
    end

    assign bus.Haddr         = haddr_s;
    assign bus.Htrans        = htrans_s;
    assign bus.Hwrite        = hwrite_s;
    assign bus.Hsize         = hsize_s;
    assign bus.Hburst        = hburst_s;
    assign bus.Hmastlock     = hmastlock_s;
    assign bus.Hwdata        = hwdata_s;
    assign bus.Hstrob        = hstrob_s;
    assign bus.Hmaster_D     = hmaster_d_q;
    assign bus.Hdphase_vld   = dphase_vld_q;
    assign bus.Hhandover_err = handover_err_q;

`ifdef M2S_PERF_CNT_EN
    logic [NUM_MASTERS-1:0][31:0] beat_cnt_d;
    logic [NUM_MASTERS-1:0][31:0] beat_cnt_q;

    // Saturating beat counters; clear wins over increment
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (bus.Hcnt_clr) begin
            beat_cnt_d = '0;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (bus.Hready && htrans_s[1] && (bus.Hmaster == MW'(i)) &&
                    (beat_cnt_q[i] != 32'hFFFF_FFFF)) begin
                    beat_cnt_d[i] = beat_cnt_q[i] + 32'd1;
                end else begin
                    beat_cnt_d[i] = beat_cnt_q[i];
                end
            end
        end
    end

    // Counter state
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.Hbeat_cnt = beat_cnt_q;
`endif
endmodule

// File: doc/ahb_m2s_pipelined_mux.md
Name: ahb_m2s_pipelined_mux

Overview:
Parametrised master-to-slave multiplexer for the multi-master AHB interconnect. It follows the arbiter.
- Address/control phase is selected combinationally by the arbiter's Hmaster.
- Write data and strobes are selected by a registered data-phase owner, captured on each Hready cycle. This gives correct AHB pipelining when ownership changes mid-stream.
- It also flags illegal handovers and masks out-of-range master indices.

Parameters:
- NUM_MASTERS, 4, number of masters (>=2, need not be a power of 2)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, write data width (multiple of 8; strobe width DATA_WIDTH/8)
- MW, clog2(NUM_MASTERS), derived index width (localparam, not overridable)

Ports:
- Hclk  in  1  bus clock
- Hresetn  in  1  asynchronous active-low reset
- Hmaster  in  MW  address-phase owner from arbiter
- Hready  in  1  bus HREADY from slave-to-master mux
- Haddr_M  in  ADDR_WIDTH x NUM_MASTERS  per-master address
- Htrans_M  in  2 x NUM_MASTERS  per-master transfer type
- Hwrite_M  in  1 x NUM_MASTERS  per-master write
- Hsize_M  in  3 x NUM_MASTERS  per-master size
- Hburst_M  in  3 x NUM_MASTERS  per-master burst
- Hmastlock_M  in  1 x NUM_MASTERS  per-master lock
- Hstrob_M  in  DATA_WIDTH/8 x NUM_MASTERS  per-master write strobes
- Hwdata_M  in  DATA_WIDTH x NUM_MASTERS  per-master write data
- Haddr  out  ADDR_WIDTH  bus address
- Htrans  out  2  bus transfer type
- Hwrite  out  1  bus write
- Hsize  out  3  bus size
- Hburst  out  3  bus burst
- Hmastlock  out  1  bus lock
- Hstrob  out  DATA_WIDTH/8  bus strobes (data phase)
- Hwdata  out  DATA_WIDTH  bus write data (data phase)
- Hmaster_D  out  MW  registered data-phase owner
- Hdphase_vld  out  1  data phase in progress (registered NONSEQ/SEQ accepted)
- Hhandover_err  out  1  one-cycle pulse, illegal handover detected

Behaviour:
- Address-phase outputs are combinational from index Hmaster: Haddr, Htrans, Hwrite, Hsize, Hburst, Hmastlock.
- If Hmaster >= NUM_MASTERS, address-phase outputs are forced: Htrans=IDLE(2'b00), Haddr=0, Hwrite=0, Hsize=0, Hburst=0, Hmastlock=0.
- On rising Hclk with Hready=1:
  - Hmaster_D <= Hmaster.
  - Hdphase_vld <= (masked Htrans == NONSEQ or SEQ), i.e. Htrans[1].
- With Hready=0, both registers hold. A stalled data phase keeps its owner even if Hmaster changes.
- Hwdata/Hstrob are combinational from index Hmaster_D. If Hmaster_D is out of range or Hdphase_vld=0, Hwdata=0 and Hstrob=0.
- Latency: address phase 0 cycles; data-phase owner switch takes effect 1 cycle after the accepting Hready edge.
- Handover check: registered previous address-phase owner prev_m, updated on Hready=1. Hhandover_err pulses for one cycle after an accepting edge where:
  - Hmaster != prev_m and masked Htrans == SEQ (new owner starting with SEQ), or
  - Hmaster != prev_m while the previous accepted cycle had Hmastlock=1 and Htrans != IDLE (lock broken).
- The error is a flag only; transfers are not altered.
- Reset (async assert, sync-deassert assumed upstream): Hmaster_D=0, prev_m=0, Hdphase_vld=0, Hhandover_err=0, perf counters 0. Hence Hwdata=0 and Hstrob=0 during reset. Address outputs remain combinational.
- Simultaneous Hmaster change and Hready=0: address outputs follow new Hmaster immediately; data-phase registers hold.

Optional Feature:
- Macro M2S_PERF_CNT_EN.
- Defined:
  - Adds output Hbeat_cnt (NUM_MASTERS x 32 bits). Counter[i] increments on each Hready=1 edge where Hmaster==i and masked Htrans is NONSEQ or SEQ.
  - Saturates at 32'hFFFF_FFFF (no wrap).
  - Adds input Hcnt_clr (1 bit): synchronous clear of all counters, with priority over increment.
- Not defined: no counters, no extra ports, no extra logic.

Test Plan:
- Reset: Hresetn=0 with Hwdata_M[0]=32'hA5A5_A5A5 -> Hwdata=0, Hstrob=0, Hmaster_D=0, Hdphase_vld=0.
- Pipelined handover: M0 NONSEQ write addr 0x100 in cycle n, Hmaster=1 NONSEQ addr 0x200 in n+1, Hready=1 -> Haddr=0x200 in n+1 while Hwdata=Hwdata_M[0]; in n+2 Hwdata=Hwdata_M[1], Hmaster_D=1.
- Stall: Hready=0 for 3 cycles after M2 write accepted, Hmaster switched to 3 -> Hwdata stays Hwdata_M[2], Hmaster_D=2 until Hready=1.
- Out of range: NUM_MASTERS=3, Hmaster=3 -> Htrans=IDLE, Haddr=0; next edge Hdphase_vld=0, Hwdata=0.
- Handover error: M1 locked NONSEQ accepted, then Hmaster=0 with Htrans_M[0]=SEQ -> Hhandover_err=1 for exactly one cycle.
- M2S_PERF_CNT_EN: M1 issues 4-beat INCR4 (NONSEQ + 3 SEQ) with one IDLE and one BUSY interleaved -> Hbeat_cnt[1]=4; Hcnt_clr pulse -> 0.
